acc_lane: RTL and testbench

Multi-lane successor of the unary product accumulator in the ugemmrate processing element. Each enabled cycle it popcounts LANES unary product bits, optionally in bipolar encoding, through a one-stage pipeline into a signed WIDTH-bit accumulator. On mac_done it folds in the upstream partial sum and presents a held, valid result. Overflow is flagged, with optional saturation. It sits between the unary multiplier lanes and the vertical partial-sum chain of the systolic array.

---
 rtl/acc_lane.sv | 131 +++++++++++++
 tb/tb_acc_lane.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_lane.sv
// acc_lane: multi-lane unary product accumulator for a systolic PE.
// Popcount stage feeds a signed accumulator with partial-sum fold-in.
module acc_lane #(
  parameter int WIDTH   = 24,
  parameter int LANES   = 4,
  parameter bit BIPOLAR = 1'b0,
  parameter bit SAT     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             mac_done,
  input  logic [LANES-1:0] prod_bits,
  input  logic [WIDTH-1:0] sum_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             sum_valid,
  output logic             ovf
);

  localparam int CW = WIDTH + 1;
  localparam int SW = WIDTH + 2;

  localparam logic signed [SW-1:0] MAXV =
    {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV =
    {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [CW-1:0] r_pc;
  logic                 r_pv;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_ovf;

  logic signed [CW-1:0] w_c;
  logic                 w_adv;
  logic                 w_fold;
  logic signed [SW-1:0] w_pc_ext;
  logic signed [SW-1:0] w_si_ext;
  logic signed [SW-1:0] w_sum_wide;
  logic                 w_hi;
  logic                 w_lo;
  logic [WIDTH-1:0]     w_sum_nxt;

  always_comb begin
    w_c = '0;
    for (int i = 0; i < LANES; i++) begin
      w_c = w_c + CW'(prod_bits[i]);
    end
    if (BIPOLAR) begin
      w_c = (w_c <<< 1) - CW'(LANES);
    end
  end

  // DONE freezes the lane until clr; en=0 freezes everything.
  assign w_adv  = en && (r_state != S_DONE);
  assign w_fold = w_adv && mac_done;

  assign w_pc_ext = r_pv ? SW'(r_pc) : '0;
  assign w_si_ext = w_fold ? SW'($signed(sum_i)) : '0;

  assign w_sum_wide = SW'($signed(r_sum))
                    + w_pc_ext
                    + w_si_ext;

  assign w_hi = (w_sum_wide > MAXV);
  assign w_lo = (w_sum_wide < MINV);

  always_comb begin
    w_sum_nxt = w_sum_wide[WIDTH-1:0];
    if (SAT && w_hi) begin
      w_sum_nxt = MAXV[WIDTH-1:0];
    end else if (SAT && w_lo) begin
      w_sum_nxt = MINV[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= '0;
      r_pv  <= 1'b0;
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_pc  <= '0;
      r_pv  <= 1'b0;
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_sum <= w_sum_nxt;
      r_ovf <= r_ovf | w_hi | w_lo;
      r_pv  <= !mac_done;
      if (!mac_done) begin
        r_pc <= w_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    priority case (1'b1)
      clr:     w_state_nxt = S_IDLE;
      w_fold:  w_state_nxt = S_DONE;
      w_adv:   w_state_nxt = S_ACC;
      default: w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    sum_valid = (r_state == S_DONE);
    sum_o     = r_sum;
    ovf       = r_ovf;
  end

endmodule

// File: tb/tb_acc_lane.sv
// tb_acc_lane: four parameterisations of acc_lane on shared stimulus,
// checked against an integer reference model plus directed values.
module tb_acc_lane;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic        mac_done;
  logic [3:0]  prod_bits;
  logic [23:0] sum_i;

  logic [23:0] so_a;
  logic [23:0] so_b;
  logic [7:0]  so_c;
  logic [7:0]  so_d;
  logic [3:0]  sv;
  logic [3:0]  ov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_lane #(.WIDTH(24), .LANES(4), .BIPOLAR(1'b0), .SAT(1'b1)) u_base (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mac_done(mac_done),
    .prod_bits(prod_bits), .sum_i(sum_i),
    .sum_o(so_a), .sum_valid(sv[0]), .ovf(ov[0]));

  acc_lane #(.WIDTH(24), .LANES(4), .BIPOLAR(1'b1), .SAT(1'b1)) u_bip (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mac_done(mac_done),
    .prod_bits(prod_bits), .sum_i(sum_i),
    .sum_o(so_b), .sum_valid(sv[1]), .ovf(ov[1]));

  acc_lane #(.WIDTH(8), .LANES(4), .BIPOLAR(1'b0), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mac_done(mac_done),
    .prod_bits(prod_bits), .sum_i(sum_i[7:0]),
    .sum_o(so_c), .sum_valid(sv[2]), .ovf(ov[2]));

  acc_lane #(.WIDTH(8), .LANES(4), .BIPOLAR(1'b0), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mac_done(mac_done),
    .prod_bits(prod_bits), .sum_i(sum_i[7:0]),
    .sum_o(so_d), .sum_valid(sv[3]), .ovf(ov[3]));

  int cfg_w[4]   = '{24, 24, 8, 8};
  bit cfg_bip[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit cfg_sat[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  // Reference: a pending contribution plus a plain integer running sum.
  longint m_sum[4];
  longint m_pend[4];
  bit     m_has[4];
  bit     m_ovf[4];
  bit     m_done[4];

  function automatic longint act_sum(int k);
    case (k)
      0:       return longint'($signed(so_a));
      1:       return longint'($signed(so_b));
      2:       return longint'($signed(so_c));
      default: return longint'($signed(so_d));
    endcase
  endfunction

  function automatic longint to_signed(longint v, int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_sum[k]  = 0;
      m_pend[k] = 0;
      m_has[k]  = 1'b0;
      m_ovf[k]  = 1'b0;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    longint s;
    longint hi;
    longint lo;
    longint p;
    for (int k = 0; k < 4; k++) begin
      hi = (longint'(1) << (cfg_w[k] - 1)) - 1;
      lo = -(longint'(1) << (cfg_w[k] - 1));
      p  = longint'($countones(prod_bits));
      if (cfg_bip[k]) p = 2 * p - 4;
      if (clr) begin
        m_sum[k]  = 0;
        m_pend[k] = 0;
        m_has[k]  = 1'b0;
        m_ovf[k]  = 1'b0;
        m_done[k] = 1'b0;
      end else if (en && !m_done[k]) begin
        s = m_sum[k] + (m_has[k] ? m_pend[k] : 0);
        if (mac_done) s = s + to_signed(longint'(sum_i), cfg_w[k]);
        if (s > hi || s < lo) begin
          m_ovf[k] = 1'b1;
          if (cfg_sat[k]) s = (s > hi) ? hi : lo;
          else s = to_signed(s, cfg_w[k]);
        end
        m_sum[k] = s;
        if (mac_done) begin
          m_has[k]  = 1'b0;
          m_done[k] = 1'b1;
        end else begin
          m_pend[k] = p;
          m_has[k]  = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit e, input bit c, input bit d,
                      input logic [3:0] b, input logic [23:0] s);
    en        = e;
    clr       = c;
    mac_done  = d;
    prod_bits = b;
    sum_i     = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0; clr = 1'b0; mac_done = 1'b0;
    prod_bits = '0; sum_i = '0;
    model_reset();
    #12;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_sum(k) !== 0 || sv[k] !== 1'b0 || ov[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset k=%0d sum=%0d valid=%b ovf=%b need 0/0/0",
                 k, act_sum(k), sv[k], ov[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_first_products();
    longint exp_seq[3] = '{0, 3, 6};
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 4'b1011, 24'd0);
      checks++;
      if (act_sum(0) !== exp_seq[i] || sv[0] !== 1'b0) begin
        errors++;
        $display("FAIL first_prod[%0d] sum=%0d valid=%b need %0d/0",
                 i, act_sum(0), sv[0], exp_seq[i]);
      end
    end
    step(1, 0, 1, 4'b1011, 24'd10);
    checks++;
    if (act_sum(0) !== 19 || sv[0] !== 1'b1) begin
      errors++;
      $display("FAIL mac_done sum=%0d valid=%b need 19/1",
               act_sum(0), sv[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, i[0], 4'($urandom), 24'($urandom));
      checks++;
      if (act_sum(0) !== 19 || sv[0] !== 1'b1) begin
        errors++;
        $display("FAIL done_hold[%0d] sum=%0d valid=%b need 19/1",
                 i, act_sum(0), sv[0]);
      end
    end
  endtask

  task automatic test_bipolar();
    step(0, 1, 0, 4'b0000, 24'd0);
    step(1, 0, 0, 4'b0001, 24'd0);
    step(1, 0, 0, 4'b0001, 24'd0);
    checks++;
    if (act_sum(1) !== -2) begin
      errors++;
      $display("FAIL bipolar_acc sum=%0d need -2", act_sum(1));
    end
    step(1, 0, 1, 4'b1111, 24'd0);
    checks++;
    if (act_sum(1) !== -4 || sv[1] !== 1'b1 || ov[1] !== 1'b0) begin
      errors++;
      $display("FAIL bipolar_done sum=%0d valid=%b ovf=%b need -4/1/0",
               act_sum(1), sv[1], ov[1]);
    end
  endtask

  task automatic test_stall();
    bit     en_pat[5]  = '{1, 0, 0, 1, 1};
    longint exp_seq[5] = '{0, 0, 0, 4, 8};
    step(0, 1, 0, 4'b0000, 24'd0);
    for (int i = 0; i < 5; i++) begin
      step(en_pat[i], 0, (i == 1), 4'b1111, 24'd0);
      checks++;
      if (act_sum(0) !== exp_seq[i] || sv[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d] sum=%0d valid=%b need %0d/0",
                 i, act_sum(0), sv[0], exp_seq[i]);
      end
    end
  endtask

  task automatic test_saturation();
    step(0, 1, 0, 4'b0000, 24'd0);
    for (int i = 0; i < 32; i++) step(1, 0, 0, 4'b1111, 24'd0);
    checks++;
    if (act_sum(2) !== 124 || act_sum(3) !== 124 || ov[2] || ov[3]) begin
      errors++;
      $display("FAIL sat_pre sat=%0d wrap=%0d ovf=%b%b need 124/124/00",
               act_sum(2), act_sum(3), ov[2], ov[3]);
    end
    step(1, 0, 0, 4'b1111, 24'd0);
    checks++;
    if (act_sum(2) !== 127 || act_sum(3) !== -128 ||
        ov[2] !== 1'b1 || ov[3] !== 1'b1) begin
      errors++;
      $display("FAIL sat_1 sat=%0d wrap=%0d ovf=%b%b need 127/-128/11",
               act_sum(2), act_sum(3), ov[2], ov[3]);
    end
    step(1, 0, 0, 4'b1111, 24'd0);
    checks++;
    if (act_sum(2) !== 127 || act_sum(3) !== -124 ||
        ov[2] !== 1'b1 || ov[3] !== 1'b1) begin
      errors++;
      $display("FAIL sat_2 sat=%0d wrap=%0d ovf=%b%b need 127/-124/11",
               act_sum(2), act_sum(3), ov[2], ov[3]);
    end
  endtask

  task automatic test_priority();
    step(1, 0, 0, 4'b1111, 24'd0);
    step(1, 0, 0, 4'b1111, 24'd0);
    step(1, 1, 1, 4'b1111, 24'd50);
    checks++;
    if (act_sum(0) !== 0 || sv[0] || ov[0] || ov[2] || ov[3]) begin
      errors++;
      $display("FAIL clr_vs_done sum=%0d valid=%b ovf=%b need 0/0/0",
               act_sum(0), sv[0], ov);
    end
    step(1, 0, 0, 4'b1111, 24'd0);
    checks++;
    if (act_sum(0) !== 0) begin
      errors++;
      $display("FAIL clr_idle sum=%0d need 0", act_sum(0));
    end
    step(1, 0, 1, 4'b0000, 24'd5);
    checks++;
    if (act_sum(0) !== 9 || sv[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_clr_done sum=%0d valid=%b need 9/1",
               act_sum(0), sv[0]);
    end
    step(0, 1, 0, 4'b0000, 24'd0);
    checks++;
    if (act_sum(0) !== 0 || sv[0] !== 1'b0) begin
      errors++;
      $display("FAIL clr_done sum=%0d valid=%b need 0/0",
               act_sum(0), sv[0]);
    end
    step(1, 0, 0, 4'b0001, 24'd0);
    step(1, 0, 0, 4'b0011, 24'd0);
    checks++;
    if (act_sum(0) !== 1) begin
      errors++;
      $display("FAIL rerun sum=%0d need 1", act_sum(0));
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, 0, 4'b0000, 24'd0);
    step(1, 0, 0, 4'b0001, 24'd0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 4'b1111, 24'd0);
    checks++;
    if (act_sum(0) !== 37) begin
      errors++;
      $display("FAIL pre_rst sum=%0d need 37", act_sum(0));
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (act_sum(0) !== 0 || act_sum(1) !== 0 || sv !== 4'b0 ||
        ov !== 4'b0) begin
      errors++;
      $display("FAIL async_rst sum=%0d bip=%0d valid=%b ovf=%b need 0",
               act_sum(0), act_sum(1), sv, ov);
    end
    model_reset();
    #2;
    rst = 1'b0;
    step(1, 0, 0, 4'b1111, 24'd0);
    checks++;
    if (act_sum(0) !== 0) begin
      errors++;
      $display("FAIL stale_pc sum=%0d need 0", act_sum(0));
    end
    step(1, 0, 0, 4'b1111, 24'd0);
    checks++;
    if (act_sum(0) !== 4) begin
      errors++;
      $display("FAIL post_rst sum=%0d need 4", act_sum(0));
    end
  endtask

  task automatic test_random();
    bit e;
    bit c;
    bit d;
    step(0, 1, 0, 4'b0000, 24'd0);
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 29) == 0);
      d = ($urandom_range(0, 19) == 0);
      step(e, c, d, 4'($urandom), 24'($signed(8'($urandom))));
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act_sum(k) !== m_sum[k] || sv[k] !== m_done[k] ||
            ov[k] !== m_ovf[k]) begin
          errors++;
          $display("FAIL rand[%0d] k=%0d sum=%0d v=%b o=%b need %0d/%b/%b",
                   i, k, act_sum(k), sv[k], ov[k],
                   m_sum[k], m_done[k], m_ovf[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_products();
    test_bipolar();
    test_stall();
    test_saturation();
    test_priority();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
